// File: rtl/r_cpu_pkg.sv
// Shared constants and types for the R_CPU board front-end blocks.
//   BYTE_W/WORD_W/NUM_BYTES : staging word geometry
//   SEL_CLEAR_BIT           : byte-select bit that turns a load into a clear
//   state_e                 : operand-entry FSM state encoding
`timescale 1ns/1ps
package r_cpu_pkg;

  localparam int unsigned BYTE_W        = 8;
  localparam int unsigned WORD_W        = 32;
  localparam int unsigned NUM_BYTES     = WORD_W / BYTE_W;
  localparam int unsigned SEL_W         = 3;
  localparam int unsigned SEL_CLEAR_BIT = 2;

  typedef enum logic {
    ST_ENTRY   = 1'b0,
    ST_PRESENT = 1'b1
  } state_e;

  // Odd number of set bits gives 1.
  function automatic logic word_parity(input logic [WORD_W-1:0] w);
    return ^w;
  endfunction

endpackage

// File: rtl/sw_word_entry_if.sv
// Operand-entry bus: switch/button inputs plus the committed-word handshake.
//   master : the entry block (drives data/valid/byte_mask[/parity])
//   slave  : the board/consumer side (drives switches, buttons, ready)
// Optional parity signal present when SW_WORD_ENTRY_PARITY_EN is defined.
`timescale 1ns/1ps
interface sw_word_entry_if;
  import r_cpu_pkg::*;

  logic [BYTE_W-1:0]    sw;
  logic [SEL_W-1:0]     sel;
  logic                 load_btn;
  logic                 commit_btn;
  logic                 ready;
  logic [WORD_W-1:0]    data;
  logic                 valid;
  logic [NUM_BYTES-1:0] byte_mask;
`ifdef SW_WORD_ENTRY_PARITY_EN
  logic                 parity;
`endif

  modport master (
    input  sw, sel, load_btn, commit_btn, ready,
`ifdef SW_WORD_ENTRY_PARITY_EN
    output parity,
`endif
    output data, valid, byte_mask
  );

  modport slave (
    output sw, sel, load_btn, commit_btn, ready,
`ifdef SW_WORD_ENTRY_PARITY_EN
    input  parity,
`endif
    input  data, valid, byte_mask
  );

endinterface

// File: rtl/sw_word_entry_btn_debounce.sv
// Push-button conditioner: 2-FF synchroniser, debounce counter, rising-edge pulse.
//   clk, rst_n : clock, async active-low reset
//   i_btn      : raw asynchronous button level
//   o_pulse    : one-cycle pulse, DEBOUNCE_CYCLES+3 clocks after a clean press
`timescale 1ns/1ps
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned CNT_W           = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_pulse
);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic             r_level_d;
  logic             r_pulse;
  logic [CNT_W-1:0] r_cnt;

  // Counter runs only while the synchronised input disagrees with the accepted
  // level, so any bounce back to the old level restarts the qualification.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
      r_pulse   <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_sync1   <= i_btn;
      r_sync2   <= r_sync1;
      r_level_d <= r_level;
      r_pulse   <= r_level & ~r_level_d;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        r_level <= r_sync2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_pulse = r_pulse;

endmodule

// File: rtl/sw_word_entry.sv
// Operand-entry front end: builds a 32-bit word byte-by-byte from slide
// switches under debounced load/commit buttons, then offers it via valid/ready.
//   SW_WORD_ENTRY_clk_xi / rst_n_xi     : clock, async active-low reset
//   SW_WORD_ENTRY_SW_xi, SEL_xi         : byte value and byte select (SEL[2]=clear)
//   SW_WORD_ENTRY_load_btn_xi           : raw load button
//   SW_WORD_ENTRY_commit_btn_xi         : raw commit button
//   SW_WORD_ENTRY_ready_xi              : consumer accept
//   SW_WORD_ENTRY_data_xo, valid_xo     : committed word and its valid
//   SW_WORD_ENTRY_byte_mask_xo          : bytes loaded since last clear/accept
//   SW_WORD_ENTRY_parity_xo             : XOR of committed word (SW_WORD_ENTRY_PARITY_EN only)
`timescale 1ns/1ps
module sw_word_entry
  import r_cpu_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned CNT_W           = 20
) (
  input  logic                 SW_WORD_ENTRY_clk_xi,
  input  logic                 SW_WORD_ENTRY_rst_n_xi,
  input  logic [BYTE_W-1:0]    SW_WORD_ENTRY_SW_xi,
  input  logic [SEL_W-1:0]     SW_WORD_ENTRY_SEL_xi,
  input  logic                 SW_WORD_ENTRY_load_btn_xi,
  input  logic                 SW_WORD_ENTRY_commit_btn_xi,
  input  logic                 SW_WORD_ENTRY_ready_xi,
  output logic [WORD_W-1:0]    SW_WORD_ENTRY_data_xo,
  output logic                 SW_WORD_ENTRY_valid_xo,
  output logic [NUM_BYTES-1:0] SW_WORD_ENTRY_byte_mask_xo
`ifdef SW_WORD_ENTRY_PARITY_EN
  ,
  output logic                 SW_WORD_ENTRY_parity_xo
`endif
);

  logic w_load_pulse;
  logic w_commit_pulse;

  state_e               r_state,   w_state_nxt;
  logic [WORD_W-1:0]    r_staging, w_staging_nxt;
  logic [WORD_W-1:0]    r_data,    w_data_nxt;
  logic                 r_valid,   w_valid_nxt;
  logic [NUM_BYTES-1:0] r_mask,    w_mask_nxt;
`ifdef SW_WORD_ENTRY_PARITY_EN
  logic                 r_parity,  w_parity_nxt;
`endif

  // Button conditioning
  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_load_db (
    .clk     (SW_WORD_ENTRY_clk_xi),
    .rst_n   (SW_WORD_ENTRY_rst_n_xi),
    .i_btn   (SW_WORD_ENTRY_load_btn_xi),
    .o_pulse (w_load_pulse)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_commit_db (
    .clk     (SW_WORD_ENTRY_clk_xi),
    .rst_n   (SW_WORD_ENTRY_rst_n_xi),
    .i_btn   (SW_WORD_ENTRY_commit_btn_xi),
    .o_pulse (w_commit_pulse)
  );

  // Next-state and datapath updates. FSM actions are evaluated on the current
  // (pre-load) mask/staging; the load is applied last so it wins for its bit
  // over an accept-clear in the same cycle.
  always_comb begin
    w_state_nxt   = r_state;
    w_staging_nxt = r_staging;
    w_data_nxt    = r_data;
    w_valid_nxt   = r_valid;
    w_mask_nxt    = r_mask;
`ifdef SW_WORD_ENTRY_PARITY_EN
    w_parity_nxt  = r_parity;
`endif

    case (r_state)
      ST_ENTRY: begin
        if (w_commit_pulse && (r_mask == '1)) begin
          w_data_nxt   = r_staging;
          w_valid_nxt  = 1'b1;
`ifdef SW_WORD_ENTRY_PARITY_EN
          w_parity_nxt = word_parity(r_staging);
`endif
          w_state_nxt  = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        if (SW_WORD_ENTRY_ready_xi) begin
          w_valid_nxt = 1'b0;
          w_mask_nxt  = '0;
          w_state_nxt = ST_ENTRY;
        end
      end
    endcase

    if (w_load_pulse) begin
      if (SW_WORD_ENTRY_SEL_xi[SEL_CLEAR_BIT]) begin
        w_staging_nxt = '0;
        w_mask_nxt    = '0;
      end else begin
        for (int b = 0; b < NUM_BYTES; b++) begin
          if (SW_WORD_ENTRY_SEL_xi[1:0] == 2'(b)) begin
            w_staging_nxt[b*BYTE_W +: BYTE_W] = SW_WORD_ENTRY_SW_xi;
            w_mask_nxt[b]                     = 1'b1;
          end
        end
      end
    end
  end

  // State and output registers
  always_ff @(posedge SW_WORD_ENTRY_clk_xi or negedge SW_WORD_ENTRY_rst_n_xi) begin
    if (!SW_WORD_ENTRY_rst_n_xi) begin
      r_state   <= ST_ENTRY;
      r_staging <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_mask    <= '0;
`ifdef SW_WORD_ENTRY_PARITY_EN
      r_parity  <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_staging <= w_staging_nxt;
      r_data    <= w_data_nxt;
      r_valid   <= w_valid_nxt;
      r_mask    <= w_mask_nxt;
`ifdef SW_WORD_ENTRY_PARITY_EN
      r_parity  <= w_parity_nxt;
`endif
    end
  end

  assign SW_WORD_ENTRY_data_xo      = r_data;
  assign SW_WORD_ENTRY_valid_xo     = r_valid;
  assign SW_WORD_ENTRY_byte_mask_xo = r_mask;
`ifdef SW_WORD_ENTRY_PARITY_EN
  assign SW_WORD_ENTRY_parity_xo    = r_parity;
`endif

endmodule

// File: tb/tb_sw_word_entry.sv
// Bench for sw_word_entry: vector table, randomized ops against a
// transaction-level model, and hand-written timing/corner sequences.
`timescale 1ns/1ps
module tb_sw_word_entry;
  import r_cpu_pkg::*;

  localparam int unsigned DC = 4;

  typedef enum int {OP_LOAD, OP_COMMIT, OP_ACCEPT} op_e;

  typedef struct {
    op_e         op;
    logic [2:0]  sel;
    logic [7:0]  sw;
    logic [31:0] exp_data;
    logic        exp_valid;
    logic [3:0]  exp_mask;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sw_word_entry_if bus();

  sw_word_entry #(.DEBOUNCE_CYCLES(DC), .CNT_W(20)) dut (
    .SW_WORD_ENTRY_clk_xi        (clk),
    .SW_WORD_ENTRY_rst_n_xi      (rst_n),
    .SW_WORD_ENTRY_SW_xi         (bus.sw),
    .SW_WORD_ENTRY_SEL_xi        (bus.sel),
    .SW_WORD_ENTRY_load_btn_xi   (bus.load_btn),
    .SW_WORD_ENTRY_commit_btn_xi (bus.commit_btn),
    .SW_WORD_ENTRY_ready_xi      (bus.ready),
    .SW_WORD_ENTRY_data_xo       (bus.data),
    .SW_WORD_ENTRY_valid_xo      (bus.valid),
    .SW_WORD_ENTRY_byte_mask_xo  (bus.byte_mask)
`ifdef SW_WORD_ENTRY_PARITY_EN
    ,
    .SW_WORD_ENTRY_parity_xo     (bus.parity)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Load-pulse monitor: count of pulses and the cycle index of the last one.
  int cyc = 0;
  int pulse_cnt = 0;
  int last_pulse_cyc = 0;
  always @(posedge clk) begin
    if (dut.w_load_pulse) begin
      pulse_cnt      <= pulse_cnt + 1;
      last_pulse_cyc <= cyc;
    end
    cyc <= cyc + 1;
  end

  // Transaction-level reference model
  logic [7:0]  m_bytes [4];
  logic [3:0]  m_mask;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_par;

  function automatic logic [31:0] m_word();
    return {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_bytes[i] = 8'h00;
    m_mask = 4'h0; m_data = 32'h0; m_valid = 1'b0; m_par = 1'b0;
  endtask

  task automatic model_op(input op_e op, input logic [2:0] sel, input logic [7:0] sw);
    case (op)
      OP_LOAD: begin
        if (sel[2]) begin
          for (int i = 0; i < 4; i++) m_bytes[i] = 8'h00;
          m_mask = 4'h0;
        end else begin
          m_bytes[sel[1:0]] = sw;
          m_mask[sel[1:0]]  = 1'b1;
        end
      end
      OP_COMMIT: begin
        if (!m_valid && m_mask == 4'hF) begin
          int ones;
          m_data  = m_word();
          m_valid = 1'b1;
          ones = 0;
          for (int i = 0; i < 32; i++) ones += int'(m_data[i]);
          m_par = 1'(ones % 2);
        end
      end
      OP_ACCEPT: begin
        if (m_valid) begin
          m_valid = 1'b0;
          m_mask  = 4'h0;
        end
      end
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    bus.sw = 8'h00; bus.sel = 3'b000; bus.load_btn = 1'b0;
    bus.commit_btn = 1'b0; bus.ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    model_reset();
  endtask

  // Clean press: long enough to debounce both press and release.
  task automatic press(input bit is_commit);
    if (is_commit) bus.commit_btn = 1'b1; else bus.load_btn = 1'b1;
    repeat (10) tick();
    bus.commit_btn = 1'b0; bus.load_btn = 1'b0;
    repeat (10) tick();
  endtask

  task automatic apply_op(input op_e op, input logic [2:0] sel, input logic [7:0] sw);
    case (op)
      OP_LOAD:   begin bus.sel = sel; bus.sw = sw; press(1'b0); end
      OP_COMMIT: press(1'b1);
      OP_ACCEPT: begin bus.ready = 1'b1; tick(); bus.ready = 1'b0; tick(); end
    endcase
  endtask

  task automatic check_model(input string tag);
    check({tag, "_data"},  bus.data,             m_data);
    check({tag, "_valid"}, 32'(bus.valid),       32'(m_valid));
    check({tag, "_mask"},  32'(bus.byte_mask),   32'(m_mask));
`ifdef SW_WORD_ENTRY_PARITY_EN
    check({tag, "_par"},   32'(bus.parity),      32'(m_par));
`endif
  endtask

  task automatic load_word(input logic [31:0] w);
    for (int b = 0; b < 4; b++) begin
      logic [31:0] tmp;
      tmp = w >> (8 * b);
      apply_op(OP_LOAD, 3'(b), tmp[7:0]);
    end
  endtask

  vec_t vecs [13];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int p_start;
    int p0;

    vecs[0]  = '{OP_LOAD,   3'b000, 8'h78, 32'h00000000, 1'b0, 4'h1};
    vecs[1]  = '{OP_LOAD,   3'b001, 8'h56, 32'h00000000, 1'b0, 4'h3};
    vecs[2]  = '{OP_LOAD,   3'b010, 8'h34, 32'h00000000, 1'b0, 4'h7};
    vecs[3]  = '{OP_LOAD,   3'b011, 8'h12, 32'h00000000, 1'b0, 4'hF};
    vecs[4]  = '{OP_COMMIT, 3'b000, 8'h00, 32'h12345678, 1'b1, 4'hF};
    vecs[5]  = '{OP_ACCEPT, 3'b000, 8'h00, 32'h12345678, 1'b0, 4'h0};
    vecs[6]  = '{OP_LOAD,   3'b000, 8'hAA, 32'h12345678, 1'b0, 4'h1};
    vecs[7]  = '{OP_LOAD,   3'b010, 8'hBB, 32'h12345678, 1'b0, 4'h5};
    vecs[8]  = '{OP_COMMIT, 3'b000, 8'h00, 32'h12345678, 1'b0, 4'h5};
    vecs[9]  = '{OP_LOAD,   3'b100, 8'hFF, 32'h12345678, 1'b0, 4'h0};
    vecs[10] = '{OP_COMMIT, 3'b000, 8'h00, 32'h12345678, 1'b0, 4'h0};
    vecs[11] = '{OP_LOAD,   3'b001, 8'h11, 32'h12345678, 1'b0, 4'h2};
    vecs[12] = '{OP_LOAD,   3'b001, 8'h22, 32'h12345678, 1'b0, 4'h2};

    // Reset state
    do_reset();
    check("reset_data",  bus.data,           32'h0);
    check("reset_valid", 32'(bus.valid),     32'h0);
    check("reset_mask",  32'(bus.byte_mask), 32'h0);

    // Vector table
    for (int i = 0; i < 13; i++) begin
      apply_op(vecs[i].op, vecs[i].sel, vecs[i].sw);
      check($sformatf("vec%0d_data", i),  bus.data,           vecs[i].exp_data);
      check($sformatf("vec%0d_valid", i), 32'(bus.valid),     32'(vecs[i].exp_valid));
      check($sformatf("vec%0d_mask", i),  32'(bus.byte_mask), 32'(vecs[i].exp_mask));
    end
    check("staging_after_clear", dut.r_staging, 32'h00002200);

    // Bounce rejection
    do_reset();
    bus.sel = 3'b000; bus.sw = 8'h55;
    p0 = pulse_cnt;
    for (int k = 0; k < 2; k++) begin
      bus.load_btn = 1'b1; repeat (2) tick();
      bus.load_btn = 1'b0; repeat (2) tick();
    end
    repeat (20) tick();
    check("bounce_mask",   32'(bus.byte_mask), 32'h0);
    check("bounce_pulses", 32'(pulse_cnt - p0), 32'h0);

    // Clean press latency and single pulse
    p_start = cyc;
    p0 = pulse_cnt;
    bus.load_btn = 1'b1;
    repeat (DC + 3) tick();
    check("latency_mask_before", 32'(bus.byte_mask), 32'h0);
    tick();
    check("latency_mask_after",  32'(bus.byte_mask), 32'h1);
    repeat (2) tick();
    bus.load_btn = 1'b0;
    repeat (10) tick();
    check("press_one_pulse", 32'(pulse_cnt - p0), 32'h1);
    check("press_latency",   32'(last_pulse_cyc - p_start), 32'(DC + 3));

    // Hold under backpressure
    do_reset();
    load_word(32'hCAFEF00D);
    apply_op(OP_COMMIT, 3'b000, 8'h00);
    check("bp_commit_data",  bus.data,       32'hCAFEF00D);
    check("bp_commit_valid", 32'(bus.valid), 32'h1);
    bus.ready = 1'b0;
    apply_op(OP_LOAD, 3'b000, 8'hAA);
    apply_op(OP_COMMIT, 3'b000, 8'h00);
    apply_op(OP_LOAD, 3'b011, 8'hBB);
    apply_op(OP_COMMIT, 3'b000, 8'h00);
    check("bp_hold_data",  bus.data,       32'hCAFEF00D);
    check("bp_hold_valid", 32'(bus.valid), 32'h1);
    bus.ready = 1'b1; tick(); bus.ready = 1'b0;
    check("bp_accept_valid", 32'(bus.valid),     32'h0);
    check("bp_accept_mask",  32'(bus.byte_mask), 32'h0);
    repeat (5) tick();
    check("bp_once_valid", 32'(bus.valid), 32'h0);
    check("bp_once_data",  bus.data,       32'hCAFEF00D);

    // Same-cycle accept and byte-1 load
    load_word(32'h01020304);
    apply_op(OP_COMMIT, 3'b000, 8'h00);
    check("same_commit_valid", 32'(bus.valid), 32'h1);
    bus.sel = 3'b001; bus.sw = 8'h77;
    bus.load_btn = 1'b1;
    repeat (DC + 3) tick();
    check("same_pre_mask", 32'(bus.byte_mask), 32'hF);
    bus.ready = 1'b1; tick(); bus.ready = 1'b0;
    check("same_valid", 32'(bus.valid),     32'h0);
    check("same_mask",  32'(bus.byte_mask), 32'h2);
    bus.load_btn = 1'b0;
    repeat (10) tick();

    // Async reset mid-PRESENT
    do_reset();
    load_word(32'h00000007);
    apply_op(OP_COMMIT, 3'b000, 8'h00);
    check("rst_pre_data",  bus.data,       32'h00000007);
    check("rst_pre_valid", 32'(bus.valid), 32'h1);
`ifdef SW_WORD_ENTRY_PARITY_EN
    check("parity_odd", 32'(bus.parity), 32'h1);
`endif
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_valid", 32'(bus.valid),     32'h0);
    check("rst_async_data",  bus.data,           32'h0);
    check("rst_async_mask",  32'(bus.byte_mask), 32'h0);
`ifdef SW_WORD_ENTRY_PARITY_EN
    check("rst_async_par",   32'(bus.parity),    32'h0);
`endif
    #3;
    rst_n = 1'b1;
    tick();
    check("rst_after_valid", 32'(bus.valid), 32'h0);

    // Randomized ops against the model
    do_reset();
    for (int n = 0; n < 40; n++) begin
      op_e         op;
      logic [2:0]  sel;
      logic [7:0]  sw;
      int          r;
      r   = int'($urandom_range(0, 9));
      op  = (r < 6) ? OP_LOAD : (r < 8) ? OP_COMMIT : OP_ACCEPT;
      sel = {($urandom_range(0, 9) == 0), 2'($urandom_range(0, 3))};
      sw  = 8'($urandom);
      apply_op(op, sel, sw);
      model_op(op, sel, sw);
      check_model($sformatf("rnd%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
